// File: rtl/mips_pkg.sv
// Shared types for the MIPS external memory port: arbiter state and grant
// encodings, counter width and the default data width.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } grant_t;

    // Counter preload so that ACCESS spans exactly waitCycles cycles
    // (the counter reaches zero on the last one).
    function automatic logic [CNT_W-1:0] waitLoad(input int waitCycles);
        return CNT_W'(waitCycles - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-stage and external-memory signals of the
// shared memory port. The arbiter takes the slave view; the pipeline side
// (or a bench) takes the master view.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              if_stall;
    logic              mem_stall;

    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ce;
    logic              ext_we;
    logic [DATA_W-1:0] ext_rdata;

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, ext_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, if_stall, mem_stall,
               ext_addr, ext_wdata, ext_ce, ext_we
    );

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, ext_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, if_stall, mem_stall,
               ext_addr, ext_wdata, ext_ce, ext_we
    );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter that times the hold period of one external access.
// The terminal flag is high whenever the count sits at zero.
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] loadValue,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    // Load takes priority; counting stops at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port external word memory shared by instruction
// fetch and the data-memory stage. One access at a time: the address and
// write data are held for WAIT_CYCLES cycles, then the winner gets a
// one-cycle ready pulse. The data stage wins ties; a fetch withdrawn
// mid-access (branch flush) still runs to completion but is not reported.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    arbState_t          state;
    arbState_t          stateNext;
    grant_t             grant;
    logic               writeFlag;
    logic               abort;
    logic [ADDR_W-1:0]  extAddrQ;
    logic [DATA_W-1:0]  extWdataQ;
    logic [DATA_W-1:0]  ifRdataQ;
    logic [DATA_W-1:0]  memRdataQ;

    logic               memReq;
    logic               anyReq;
    logic               startAccess;
    logic               lastAccess;
    logic [CNT_W-1:0]   waitCount;
    logic               waitDone;
    logic               ifReady;
    logic               memReady;

    // Byte-address bits outside the external word address are not used.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

    assign memReq      = bus.mem_r_en | bus.mem_w_en;
    assign anyReq      = memReq | bus.if_req;
    assign startAccess = (state == IDLE) && anyReq;
    assign lastAccess  = (state == ACCESS) && waitDone;

    wait_counter #(
        .CNT_W (CNT_W)
    ) u_waitCounter (
        .clk       (clk),
        .rst       (rst),
        .load      (startAccess),
        .enable    (state == ACCESS),
        .loadValue (waitLoad(WAIT_CYCLES)),
        .count     (waitCount),
        .terminal  (waitDone)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: IDLE until a request, ACCESS until the counter expires,
    // then a single DONE cycle in which no requests are sampled.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (anyReq)   stateNext = ACCESS;
            ACCESS:  if (waitDone) stateNext = DONE;
            DONE:                  stateNext = IDLE;
            default:               stateNext = IDLE;
        endcase
    end

    // Grant capture, held external address/data, flush tracking and
    // read-data capture on the final ACCESS cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= GNT_NONE;
            writeFlag <= 1'b0;
            abort     <= 1'b0;
            extAddrQ  <= '0;
            extWdataQ <= '0;
            ifRdataQ  <= '0;
            memRdataQ <= '0;
        end else begin
            if (startAccess) begin
                abort <= 1'b0;
                if (memReq) begin
                    grant     <= GNT_MEM;
                    writeFlag <= bus.mem_w_en;
                    extAddrQ  <= bus.mem_addr[ADDR_W+1:2];
                    extWdataQ <= bus.mem_wdata;
                end else begin
                    grant     <= GNT_IF;
                    writeFlag <= 1'b0;
                    extAddrQ  <= bus.if_addr[ADDR_W+1:2];
                end
            end

            // A fetch dropped at any point of its access is abandoned,
            // including a drop on the very cycle the data is captured.
            if ((state == ACCESS) && (grant == GNT_IF) && !bus.if_req) begin
                abort <= 1'b1;
            end

            if (lastAccess) begin
                if ((grant == GNT_MEM) && !writeFlag) begin
                    memRdataQ <= bus.ext_rdata;
                end
                if ((grant == GNT_IF) && !abort && bus.if_req) begin
                    ifRdataQ <= bus.ext_rdata;
                end
            end

            if (state == DONE) begin
                grant <= GNT_NONE;
                abort <= 1'b0;
            end
        end
    end

    assign ifReady  = (state == DONE) && (grant == GNT_IF) && !abort;
    assign memReady = (state == DONE) && (grant == GNT_MEM);

    assign bus.if_ready  = ifReady;
    assign bus.mem_ready = memReady;
    assign bus.if_rdata  = ifRdataQ;
    assign bus.mem_rdata = memRdataQ;
    assign bus.if_stall  = bus.if_req & ~ifReady;
    assign bus.mem_stall = memReq & ~memReady;
    assign bus.ext_addr  = extAddrQ;
    assign bus.ext_wdata = extWdataQ;
    assign bus.ext_ce    = (state == ACCESS);
    assign bus.ext_we    = (state == ACCESS) && writeFlag;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port external word memory between instruction fetch and the data-memory stage of the 5-stage MIPS pipeline.
- Holds the external address, write data and strobes stable for a fixed number of wait cycles per access.
- Returns read data with a one-cycle ready pulse per requester.
- Produces the stall signals the pipeline top uses to freeze the IF and MEM stages while an access is outstanding.

Parameters:
- DATA_W, 32, data width of both requesters and the external port.
- ADDR_W, 18, external word-address width; byte address bits [ADDR_W+1:2] are used.
- WAIT_CYCLES, 4, number of cycles the external port is held per access; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch read request; level, held until if_ready.
- if_addr  in  32  fetch byte address (PC).
- if_rdata  out  DATA_W  fetched instruction word.
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- mem_r_en  in  1  data read request; level.
- mem_w_en  in  1  data write request; level.
- mem_addr  in  32  data byte address (ALU result).
- mem_wdata  in  DATA_W  store value.
- mem_rdata  out  DATA_W  load value.
- mem_ready  out  1  one-cycle pulse: data access complete.
- if_stall  out  1  if_req & ~if_ready.
- mem_stall  out  1  (mem_r_en | mem_w_en) & ~mem_ready.
- ext_addr  out  ADDR_W  external word address.
- ext_wdata  out  DATA_W  external write data.
- ext_ce  out  1  external chip enable.
- ext_we  out  1  external write enable.
- ext_rdata  in  DATA_W  external read data.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, counter=0, grant=NONE, abort=0.
  - ext_ce=0, ext_we=0, ext_addr=0, ext_wdata=0.
  - if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0.
  - Reset mid-access abandons the access with no ready pulse.
- FSM states:
  - IDLE -> ACCESS when any request is present. Grant, address, write data and write flag are registered on that edge.
  - ACCESS lasts exactly WAIT_CYCLES cycles, counted down by a 4-bit counter. ext_ce=1 throughout. ext_we=1 throughout when the grant is a write. ext_addr and ext_wdata stay constant.
  - On the last ACCESS cycle ext_rdata is captured into the granted requester's rdata register. On a write, mem_rdata is unchanged.
  - ACCESS -> DONE. DONE lasts 1 cycle: the granted ready pulse is 1, ext_ce=0, and no requests are sampled.
  - DONE -> IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle 0: ready at cycle WAIT_CYCLES+1.
  - Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Priority:
  - MEM beats IF when both are present in IDLE; IF is granted on the next IDLE.
  - mem_w_en beats mem_r_en if both are high (write performed).
- Withdrawal:
  - If if_req drops during ACCESS (branch flush), abort=1. The access completes, if_ready is suppressed, if_rdata is not updated and abort is cleared.
  - MEM requests must not drop before mem_ready; if they do, behaviour is undefined (assertion in the bench).
- rdata registers hold their value until the next capture for the same requester.
- Stall outputs are combinational from the request and ready signals. Ready pulses occur only in DONE and never both in the same cycle.

Decomposition:
- Shared package mips_pkg:
  - state encoding (IDLE, ACCESS, DONE);
  - grant encoding (NONE, IF, MEM);
  - DATA_W default.
- One natural sub-module, wait_counter: loadable down-counter with a terminal-count flag. The FSM and arbitration stay in mem_port_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, ext_rdata=0x2001_0005 → ext_addr=4 for 4 cycles, if_ready pulse at cycle 5, if_rdata=0x2001_0005.
- Store: mem_w_en=1, mem_addr=0x400, mem_wdata=0xDEAD_BEEF → ext_we=1 and ext_addr=0x100 for 4 cycles, mem_ready at cycle 5, mem_rdata unchanged.
- Simultaneous: if_req=1 and mem_r_en=1 at cycle 0 → MEM granted first (mem_ready cycle 5), IF granted at cycle 6 (if_ready cycle 11). if_stall=1 on cycles 0–10.
- Flush: if_req drops at cycle 2 of a fetch → no if_ready, if_rdata unchanged, FSM returns to IDLE at cycle 6.
- Reset mid-access: rst=1 at cycle 3 of a store → ext_ce and ext_we go to 0 immediately with no mem_ready. After release, a new read completes normally.
- WAIT_CYCLES=1: back-to-back reads → ready on cycle 2, next grant cycle 3, ready cycle 5.
